ring_burst_writer: RTL and testbench

RING_BURST_WRITER -- requirements
Module: ring_burst_writer

---
 rtl/ring_burst_writer.sv | 131 +++++++++++++
 tb/tb_ring_burst_writer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_burst_writer.sv
// Drains an upstream FIFO into write bursts that walk a byte-addressed ring buffer.
// Optional partial flush of a stalled FIFO after an idle timeout: define RING_FLUSH_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for a full burst (or a flush timeout) in the FIFO
//   CMD   | burst command presented, waiting for i_cmd_ready
//   DATA  | streaming beats straight from the FIFO head
module ring_burst_writer #(
    parameter int            BW        = 32,
    parameter int            LGFLEN    = 4,
    parameter int            BURST_LEN = 8,
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RING_BASE = '0,
    parameter int            RING_SIZE = 4096,
    parameter int            TIMEOUT   = 64
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [BW-1:0]   i_fifo_data,
    input  logic            i_fifo_empty,
    input  logic [LGFLEN:0] i_fifo_fill,
    output logic            o_fifo_rd,
    output logic            o_cmd_valid,
    input  logic            i_cmd_ready,
    output logic [AW-1:0]   o_cmd_addr,
    output logic [7:0]      o_cmd_len,
    output logic            o_wdata_valid,
    input  logic            i_wdata_ready,
    output logic [BW-1:0]   o_wdata,
    output logic            o_wdata_last,
    output logic [AW-1:0]   o_wr_offset,
    output logic            o_busy
);
    localparam int          BSHIFT  = $clog2(BW / 8);
    localparam int          OFF_W   = $clog2(RING_SIZE);
    localparam logic [31:0] BURST_W = 32'(BURST_LEN);
    localparam logic [31:0] RING_W  = 32'(RING_SIZE);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
    state_t state, state_nxt;

    logic [OFF_W-1:0] offset;
    logic [7:0]       len_m1;
    logic [7:0]       beat_rem;
    logic [31:0]      fill_w;
    logic [31:0]      rem_words;
    logic [31:0]      burst_words;
    logic             full_go;
    logic             flush_go;
    logic             beat_acc;
    logic             last_acc;

    assign fill_w    = 32'(i_fifo_fill);
    assign rem_words = (RING_W - 32'(offset)) >> BSHIFT;
    assign full_go   = fill_w >= BURST_W;

    // Bursts are clipped at the ring end so none ever straddles the wrap.
    always_comb begin
        burst_words = full_go ? BURST_W : fill_w;
        if (rem_words < burst_words)
            burst_words = rem_words;
    end

`ifdef RING_FLUSH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_timer;
    logic          idle_qual;

    assign idle_qual = (state == IDLE) && !i_fifo_empty && !full_go;
    assign flush_go  = idle_qual && (idle_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            idle_timer <= '0;
        else if (idle_qual && !flush_go)
            idle_timer <= idle_timer + 1'b1;
        else
            idle_timer <= '0;
    end
`else
    assign flush_go = 1'b0;
`endif

    assign beat_acc = o_wdata_valid && i_wdata_ready;
    assign last_acc = beat_acc && (beat_rem == 8'd0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full_go || flush_go) state_nxt = CMD;
            CMD:     if (i_cmd_ready) state_nxt = DATA;
            DATA:    if (last_acc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            offset   <= '0;
            len_m1   <= '0;
            beat_rem <= '0;
        end else begin
            if ((state == IDLE) && (full_go || flush_go))
                len_m1 <= 8'(burst_words - 32'd1);
            if ((state == CMD) && i_cmd_ready)
                beat_rem <= len_m1;
            else if (beat_acc && (beat_rem != 8'd0))
                beat_rem <= beat_rem - 8'd1;
            if (last_acc)
                offset <= offset + OFF_W'((32'(len_m1) + 32'd1) << BSHIFT);
        end
    end

    // Valid is held off on an empty FIFO so a pop can never underflow it.
    assign o_cmd_valid   = (state == CMD);
    assign o_cmd_addr    = RING_BASE + AW'(offset);
    assign o_cmd_len     = len_m1;
    assign o_wdata_valid = (state == DATA) && !i_fifo_empty;
    assign o_wdata       = i_fifo_data;
    assign o_wdata_last  = o_wdata_valid && (beat_rem == 8'd0);
    assign o_fifo_rd     = beat_acc;
    assign o_wr_offset   = AW'(offset);
    assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_ring_burst_writer.sv
// Bench for ring_burst_writer: queue-free FIFO model, ring-offset model and beat scoreboard.
module tb_ring_burst_writer;
    localparam int RING_BASE = 0;
    localparam int RING_SIZE = 4096;
    localparam int TIMEOUT   = 64;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic [4:0]  fifo_fill;
    logic        fifo_rd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        wdata_last;
    logic [31:0] wr_offset;
    logic        busy;

    ring_burst_writer dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_fifo_data   (fifo_data),
        .i_fifo_empty  (fifo_empty),
        .i_fifo_fill   (fifo_fill),
        .o_fifo_rd     (fifo_rd),
        .o_cmd_valid   (cmd_valid),
        .i_cmd_ready   (cmd_ready),
        .o_cmd_addr    (cmd_addr),
        .o_cmd_len     (cmd_len),
        .o_wdata_valid (wdata_valid),
        .i_wdata_ready (wdata_ready),
        .o_wdata       (wdata),
        .o_wdata_last  (wdata_last),
        .o_wr_offset   (wr_offset),
        .o_busy        (busy)
    );

    always #5 i_clk = ~i_clk;

    // Upstream FIFO: every pushed word is logged, head is log[rd_cnt].
    logic [31:0] push_log [0:4095];
    int          wr_cnt;
    int          rd_cnt = 0;
    logic        fifo_flush;

    assign fifo_data  = push_log[rd_cnt[11:0]];
    assign fifo_fill  = 5'(wr_cnt - rd_cnt);
    assign fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge i_clk) begin
        if (fifo_flush)
            rd_cnt <= wr_cnt;
        else if (fifo_rd)
            rd_cnt <= rd_cnt + 1;
    end

    int          n_chk, n_pass;
    int          m_off, m_beat, m_len, exp_len, exp_idx;
    int          burst_done, cmd_cnt, pops, beats_total;
    logic        in_burst, pend;
    logic [31:0] last_cmd_addr, pend_addr;
    logic [7:0]  last_cmd_len, pend_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    endtask

    task automatic monitor();
        if (cmd_valid) begin
            chk("one_outstanding", 64'(in_burst), 64'd0);
            chk("cmd_addr", 64'(cmd_addr), 64'(RING_BASE + m_off));
            chk("cmd_len", 64'(cmd_len), 64'(exp_len));
            if (pend) begin
                chk("cmd_addr_stable", 64'(cmd_addr), 64'(pend_addr));
                chk("cmd_len_stable", 64'(cmd_len), 64'(pend_len));
            end
            if (cmd_ready) begin
                in_burst = 1'b1; m_beat = 0; m_len = exp_len; cmd_cnt++;
                last_cmd_addr = cmd_addr; last_cmd_len = cmd_len; pend = 1'b0;
            end else begin
                pend = 1'b1; pend_addr = cmd_addr; pend_len = cmd_len;
            end
        end
        chk("fifo_rd_eq", 64'(fifo_rd), 64'(wdata_valid && wdata_ready));
        if (fifo_empty)
            chk("rd_when_empty", 64'(fifo_rd), 64'd0);
        if (fifo_rd)
            pops++;
        if (wdata_valid) begin
            chk("beat_in_burst", 64'(in_burst), 64'd1);
            chk("wdata", 64'(wdata), 64'(push_log[exp_idx[11:0]]));
            chk("wdata_last", 64'(wdata_last), 64'(m_beat == m_len));
            if (wdata_ready) begin
                exp_idx++; beats_total++;
                if (m_beat == m_len) begin
                    in_burst = 1'b0;
                    m_off = (m_off + (m_len + 1) * 4) % RING_SIZE;
                    burst_done++;
                end else begin
                    m_beat++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        if (i_reset_n)
            monitor();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            push_log[wr_cnt[11:0]] = $urandom;
            wr_cnt++;
        end
    endtask

    task automatic wait_bursts(input int target, input int budget);
        int n;
        n = 0;
        while (burst_done < target && n < budget) begin
            tick();
            n++;
        end
        chk("burst_done", 64'(burst_done), 64'(target));
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        while (!cmd_valid && n < 300) begin
            tick();
            n++;
        end
        chk("cmd_seen", 64'(cmd_valid), 64'd1);
    endtask

    initial begin
        int n, base_pops, base_beats, base_cmds;
        n_chk = 0; n_pass = 0; wr_cnt = 0; fifo_flush = 1'b0;
        m_off = 0; m_beat = 0; m_len = 0; exp_len = 7; exp_idx = 0;
        burst_done = 0; cmd_cnt = 0; pops = 0; beats_total = 0;
        in_burst = 1'b0; pend = 1'b0; last_cmd_addr = '0; pend_addr = '0;
        last_cmd_len = '0; pend_len = '0;
        i_reset_n = 1'b0; cmd_ready = 1'b0; wdata_ready = 1'b0;

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_wdata_valid", 64'(wdata_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_addr", 64'(cmd_addr), 64'(RING_BASE));
        chk("rst_offset", 64'(wr_offset), 64'd0);
        i_reset_n = 1'b1;

        // Single full burst, both readies high.
        cmd_ready = 1'b1; wdata_ready = 1'b1; exp_len = 7;
        push(8);
        wait_bursts(1, 100);
        chk("s1_addr", 64'(last_cmd_addr), 64'h0);
        chk("s1_len", 64'(last_cmd_len), 64'd7);
        chk("s1_beats", 64'(beats_total), 64'd8);
        chk("s1_offset", 64'(wr_offset), 64'h20);

        // Fill the whole 4 KiB ring and wrap.
        for (int b = 2; b <= 128; b++) begin
            push(8);
            wait_bursts(b, 100);
        end
        chk("wrap_last_addr", 64'(last_cmd_addr), 64'hFE0);
        chk("wrap_offset", 64'(wr_offset), 64'h0);
        push(8);
        wait_bursts(129, 100);
        chk("wrap_next_addr", 64'(last_cmd_addr), 64'h0);
        chk("wrap_next_offset", 64'(wr_offset), 64'(m_off));

        // Back-pressure: command stalled 10 cycles, data ready toggling.
        cmd_ready = 1'b0; wdata_ready = 1'b0; base_pops = pops;
        push(8);
        wait_cmd(n);
        repeat (10) tick();
        chk("stall_no_pop", 64'(pops - base_pops), 64'd0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        n = 0;
        while (burst_done < 130 && n < 300) begin
            wdata_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("bp_burst_done", 64'(burst_done), 64'd130);
        chk("bp_pops", 64'(pops - base_pops), 64'd8);
        chk("bp_offset", 64'(wr_offset), 64'h40);

        // Reset in the middle of a burst, while beat 3 is on the bus.
        cmd_ready = 1'b1; wdata_ready = 1'b1;
        push(8);
        n = 0;
        while (!(in_burst && m_beat == 2) && n < 100) begin
            tick();
            n++;
        end
        chk("beat3_reached", 64'(m_beat), 64'd2);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("arst_wdata_valid", 64'(wdata_valid), 64'd0);
        chk("arst_wdata_last", 64'(wdata_last), 64'd0);
        chk("arst_fifo_rd", 64'(fifo_rd), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_offset", 64'(wr_offset), 64'd0);
        chk("arst_cmd_addr", 64'(cmd_addr), 64'(RING_BASE));
        m_off = 0; m_beat = 0; in_burst = 1'b0; pend = 1'b0;
        fifo_flush = 1'b1;
        @(posedge i_clk);
        #1;
        fifo_flush = 1'b0;
        exp_idx = wr_cnt;
        i_reset_n = 1'b1;
        base_beats = beats_total;
        repeat (20) tick();
        chk("post_rst_beats", 64'(beats_total - base_beats), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);

`ifdef RING_FLUSH_TIMEOUT_EN
        // Walk to 0xFE0, then two 3-word timeout flushes land the offset on 0xFF8.
        exp_len = 7;
        for (int b = 1; b <= 127; b++) begin
            push(8);
            wait_bursts(burst_done + 1, 100);
        end
        chk("to_pre_offset", 64'(wr_offset), 64'hFE0);
        for (int k = 0; k < 2; k++) begin
            exp_len = 2;
            push(3);
            wait_cmd(n);
            chk("to_latency", 64'(n), 64'(TIMEOUT));
            chk("to_len", 64'(cmd_len), 64'd2);
            wait_bursts(burst_done + 1, 100);
        end
        chk("to_offset_ff8", 64'(wr_offset), 64'hFF8);
        exp_len = 1;
        push(5);
        wait_cmd(n);
        chk("edge_latency", 64'(n), 64'(TIMEOUT));
        chk("edge_addr", 64'(cmd_addr), 64'hFF8);
        wait_bursts(burst_done + 1, 100);
        chk("edge_wrap", 64'(wr_offset), 64'h0);
        exp_len = 2;
        wait_cmd(n);
        chk("edge2_latency", 64'(n), 64'(TIMEOUT));
        chk("edge2_addr", 64'(cmd_addr), 64'h0);
        wait_bursts(burst_done + 1, 100);
        chk("edge2_offset", 64'(wr_offset), 64'hC);
`else
        // Short residue must sit in the FIFO forever.
        base_cmds = cmd_cnt;
        push(3);
        repeat (200) tick();
        chk("no_flush_cmds", 64'(cmd_cnt - base_cmds), 64'd0);
        chk("no_flush_busy", 64'(busy), 64'd0);
        chk("no_flush_fill", 64'(fifo_fill), 64'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
